icache_fetch: RTL
=================

// Module: icache_fetch
// PURPOSE
//  Direct-mapped instruction cache serving the CPU core's instruction fetch port (en/addr/data).
//  Sits between the core's pc stage and a slow backing instruction memory.
//  Hits return the instruction combinationally.
//  Misses raise stall_req and run a line refill burst over a req/ack memory handshake.
// PARAMETERS
//  LINES       16  number of cache lines, power of 2 (>=2)
//  LINE_WORDS  4   32-bit words per line, power of 2 (>=2)
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  rst         in   1   asynchronous active-low reset
//  fetch_en    in   1   fetch request valid from core
//  fetch_addr  in   32  byte address; bits[1:0] ignored
//  fetch_data  out  32  instruction; valid when fetch_en && !stall_req
//  stall_req   out  1   pipeline stall request, high while a miss is outstanding
//  flush       in   1   invalidate all lines
//  mem_req     out  1   backing-memory read request
//  mem_addr    out  32  word-aligned byte address of the current burst beat
//  mem_ack     in   1   beat accepted, mem_rdata valid this cycle
//  mem_rdata   in   32  read data
//  hit_cnt     out  32  hit counter (ICACHE_STATS_EN only)
//  miss_cnt    out  32  miss counter (ICACHE_STATS_EN only)
// BEHAVIOUR
//  Address split: offset = addr[1:0]; word = next log2(LINE_WORDS) bits; index = next log2(LINES) bits; tag = the rest.
//  Storage: per-line valid bit and tag register, plus a LINES*LINE_WORDS x 32 data array in flops.
//  Reset (rst=0, async): all valid=0, FSM=IDLE, mem_req=0, mem_addr=0, beat counter=0, stats=0.
//  Outputs during reset: fetch_data=0, stall_req=0.
//  fetch_en=0: fetch_data=0, stall_req=0, no state change, no counter update.
//  FSM IDLE:
//   - Hit (valid && tag match): fetch_data=line word, stall_req=0. Zero added latency.
//   - Miss: stall_req=1 combinationally this cycle. Latch the line base address (addr with word and offset bits zeroed). Go to REFILL.
//  FSM REFILL:
//   - mem_req=1, stall_req=1, fetch_data=0.
//   - mem_addr = base + 4*beat. Beats run in order 0..LINE_WORDS-1.
//   - Each cycle with mem_ack=1: write mem_rdata to word[beat], then beat++.
//   - On last beat ack: set tag and valid, mem_req drops next cycle, go to IDLE.
//   - The next IDLE cycle re-evaluates and hits.
//  Miss penalty, zero-wait memory: stall on the miss cycle plus LINE_WORDS beats. Total stall = LINE_WORDS+1 cycles.
//  Core holds fetch_addr stable while stall_req=1. The cache uses only the latched base address during REFILL.
//  The refilled line's previous valid bit is cleared on REFILL entry, so a partial line is never hit.
//  flush in IDLE: all valid=0 at next edge. Same-cycle lookup still uses pre-flush state.
//  flush in REFILL: clear all valid, abort burst (mem_req=0 next cycle), return to IDLE.
//   - An ack in the same cycle as flush is dropped.
//   - Core re-misses on the next cycle.
//  Reset mid-refill: burst aborted immediately; mem_req=0 asynchronously via reset.
//  Indexes wrap naturally (modulo LINES). mem_addr never crosses the line boundary.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//   - hit_cnt++ on each IDLE hit cycle with fetch_en=1.
//   - miss_cnt++ on each IDLE->REFILL transition.
//   - Both wrap at 2^32 and are cleared by rst only.
//  Undefined: hit_cnt/miss_cnt ports absent; no counter logic.
// TESTING
//  1. Cold miss: rst release; fetch_en=1, addr=0x100; mem acks every cycle with data 0xA0..0xA3.
//     Expect stall_req=1 for 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, then fetch_data=0xA0 with stall_req=0.
//  2. Line hits: after test 1, addr=0x104/0x108/0x10C. Expect 0xA1/0xA2/0xA3 same cycle, stall_req=0, mem_req=0.
//  3. Conflict eviction: addr=0x100 (default params: tag differs, same index).
//     Expect a miss at 0x500, refill 0x500..0x50C, then 0x100 misses again.
//  4. Wait states: mem_ack high every 3rd cycle during refill of 0x200.
//     Expect mem_addr to hold per beat, 4 beats, stall held until the cycle after the 4th ack.
//  5. Flush mid-refill: assert flush on the 2nd beat.
//     Expect mem_req=0 next cycle, then a fresh miss with a burst restarting at beat 0.
//  6. Async reset during REFILL: mem_req and stall_req drop at once.
//     After release, a hit-address fetch misses (all invalid). With ICACHE_STATS_EN, counters read 0.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with a req/ack line refill burst from backing memory.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counters.
module icache_fetch #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        stall_req,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
`ifdef ICACHE_STATS_EN
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`else
  input  logic [31:0] mem_rdata
`endif
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - 2 - WB - IB;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t           state_r;
  logic [LINES-1:0] valid_r;
  logic [TB-1:0]    tag_r  [LINES];
  logic [31:0]      data_r [LINES*LINE_WORDS];
  logic [31:0]      base_r;
  logic [WB-1:0]    beat_r;

  logic [WB-1:0] word_s;
  logic [IB-1:0] idx_s;
  logic [TB-1:0] tag_s;
  logic [IB-1:0] ref_idx_s;
  logic          hit_s;
  logic          last_s;
  logic          unused_s;

  assign word_s    = fetch_addr[2 +: WB];
  assign idx_s     = fetch_addr[2+WB +: IB];
  assign tag_s     = fetch_addr[31 -: TB];
  assign ref_idx_s = base_r[2+WB +: IB];
  assign hit_s     = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign last_s    = (beat_r == WB'(LINE_WORDS - 1));
  assign unused_s  = ^{fetch_addr[1:0], base_r[2+WB-1:0]};

  // Fetch port: hits answer in the same cycle; any miss or refill stalls the core
  always_comb begin
    fetch_data = 32'h0;
    stall_req  = 1'b0;
    if (!rst) begin
      fetch_data = 32'h0;
      stall_req  = 1'b0;
    end else if (state_r == REFILL) begin
      stall_req = 1'b1;
    end else if (fetch_en) begin
      if (hit_s) begin
        fetch_data = data_r[{idx_s, word_s}];
      end else begin
        stall_req = 1'b1;
      end
    end else begin
      stall_req = 1'b0;
    end
  end

  // Control FSM: miss detection, burst sequencing, flush and valid bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      valid_r  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      beat_r   <= '0;
      base_r   <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end else if (fetch_en && !hit_s) begin
            // The line being replaced must not hit while only partly refilled.
            valid_r[idx_s] <= 1'b0;
            base_r         <= {fetch_addr[31:2+WB], {(2+WB){1'b0}}};
            mem_addr       <= {fetch_addr[31:2+WB], {(2+WB){1'b0}}};
            mem_req        <= 1'b1;
            beat_r         <= '0;
            state_r        <= REFILL;
          end else begin
            state_r <= IDLE;
          end
        end
        REFILL: begin
          if (flush) begin
            valid_r <= '0;
            mem_req <= 1'b0;
            beat_r  <= '0;
            state_r <= IDLE;
          end else if (mem_ack) begin
            if (last_s) begin
              valid_r[ref_idx_s] <= 1'b1;
              mem_req            <= 1'b0;
              beat_r             <= '0;
              state_r            <= IDLE;
            end else begin
              beat_r   <= beat_r + WB'(1);
              mem_addr <= {base_r[31:2+WB], beat_r + WB'(1), 2'b00};
            end
          end else begin
            state_r <= REFILL;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Line storage: accepted beats land in the data array; the tag is written with the last beat
  always_ff @(posedge clk) begin
    if (state_r == REFILL && mem_ack && !flush) begin
      data_r[{ref_idx_s, beat_r}] <= mem_rdata;
      if (last_s) begin
        tag_r[ref_idx_s] <= base_r[31 -: TB];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit/miss statistics, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (state_r == IDLE && fetch_en) begin
      if (hit_s) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else if (!flush) begin
        miss_cnt <= miss_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt;
      end
    end else begin
      hit_cnt <= hit_cnt;
    end
  end
`endif

endmodule
